// File: rtl/axi_read_master.sv
// axi_read_master: single-outstanding AXI3 read initiator.
// Takes one burst command from a local client, drives the AR channel,
// collects R beats (checking ID, response and beat count) and hands every
// beat to the client through a one-entry registered output stage.
// Optional build macro AXI_RM_TIMEOUT_EN adds a watchdog that aborts a
// stalled transaction after TimeoutCycles cycles without a handshake.
module axi_read_master #(
  parameter int BusWidth      = 32,
  parameter int TagBits       = 4,
  parameter int TimeoutCycles = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // client command
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [TagBits-1:0]  cmd_id,
  input  logic [BusWidth-1:0] cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [1:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  // client read data
  output logic [BusWidth-1:0] rd_data,
  output logic [1:0]          rd_resp,
  output logic                rd_last,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                busy,
  output logic                err,
  // AR channel
  output logic [TagBits-1:0]  ARID,
  output logic [BusWidth-1:0] ARADDR,
  output logic [3:0]          ARLEN,
  output logic [1:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic [1:0]          ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  // R channel
  input  logic [TagBits-1:0]  RID,
  input  logic [BusWidth-1:0] RDATA,
  input  logic [1:0]          RESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t     state;
  logic [3:0] cnt;     // beats still expected after the current one
  logic       ar_hs;
  logic       r_hs;
  logic       timeout;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // Take a new beat only when the output slot is empty or emptying this cycle.
  assign RREADY    = (state == DATA) && (!rd_valid || rd_ready);
  assign ARLOCK    = 2'b00;
  assign ARCACHE   = 4'b0000;
  assign ARPROT    = 3'b000;
  assign ar_hs     = ARVALID && ARREADY;
  assign r_hs      = RVALID && RREADY;

`ifdef AXI_RM_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wdog;

  // Watchdog fires on the TimeoutCycles-th consecutive cycle without a handshake.
  assign timeout = ((state == ADDR) || (state == DATA)) && !ar_hs && !r_hs &&
                   (wdog == WdW'(TimeoutCycles - 1));

  // Watchdog counter: cleared by any AR/R handshake or outside ADDR/DATA.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wdog <= '0;
    end else if (((state == ADDR) || (state == DATA)) && !timeout) begin
      if (ar_hs || r_hs) wdog <= '0;
      else               wdog <= wdog + WdW'(1);
    end else begin
      wdog <= '0;
    end
  end
`else
  // Without the watchdog the block waits indefinitely; the limit is unused.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout = 1'b0;
`endif

  // Main FSM with AR registers, beat counter, error flag and output stage.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      ARID     <= '0;
      ARADDR   <= '0;
      ARLEN    <= '0;
      ARSIZE   <= '0;
      ARBURST  <= '0;
      ARVALID  <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
      rd_resp  <= '0;
      rd_last  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      // Output slot empties on a client handshake unless refilled below.
      if (rd_valid && rd_ready) rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ARID    <= cmd_id;
            ARADDR  <= cmd_addr;
            ARLEN   <= cmd_len;
            ARSIZE  <= cmd_size;
            ARBURST <= cmd_burst;
            cnt     <= cmd_len;
            err     <= 1'b0;
            // An illegal size never reaches the bus.
            ARVALID <= (cmd_size != 2'b11);
            state   <= ADDR;
          end
        end

        ADDR: begin
          if (ARSIZE == 2'b11) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (ARREADY) begin
            ARVALID <= 1'b0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (r_hs) begin
            rd_data  <= RDATA;
            rd_resp  <= RESP;
            rd_valid <= 1'b1;
            if ((RID != ARID) || (RESP != 2'b00)) err <= 1'b1;
            if (cnt == 4'd0) begin
              // Expected final beat; a missing RLAST is flagged and forced.
              rd_last <= 1'b1;
              state   <= DRAIN;
              if (!RLAST) err <= 1'b1;
            end else if (RLAST) begin
              // Early last terminates the burst.
              rd_last <= 1'b1;
              err     <= 1'b1;
              state   <= DRAIN;
            end else begin
              rd_last <= 1'b0;
              cnt     <= cnt - 4'd1;
            end
          end
        end

        DRAIN: begin
          if (!rd_valid || rd_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Watchdog abort overrides the normal transitions.
      if (timeout) begin
        err     <= 1'b1;
        ARVALID <= 1'b0;
        state   <= DRAIN;
        if (!rd_valid || rd_ready) begin
          rd_valid <= 1'b1;
          rd_last  <= 1'b1;
          rd_resp  <= 2'b10;
          rd_data  <= '0;
        end
      end
    end
  end

endmodule
